// File: rtl/lamp_pwm_driver_if.sv
// Brightness-code bundle between the lamp FSM (master) and the PWM driver (slave).
// Carries enable, six 2-bit codes, and the LED/frame-start outputs back.
interface lamp_pwm_driver_if;
    logic       en;
    logic [1:0] LDC;
    logic [1:0] LDB;
    logic [1:0] LDA;
    logic [1:0] RDA;
    logic [1:0] RDB;
    logic [1:0] RDC;
    logic [5:0] led;
    logic       frame_start;

    modport master (
        output en, LDC, LDB, LDA, RDA, RDB, RDC,
        input  led, frame_start
    );

    modport slave (
        input  en, LDC, LDB, LDA, RDA, RDB, RDC,
        output led, frame_start
    );
endinterface

// File: rtl/lamp_pwm_driver.sv
// Six-channel tail-lamp PWM: 4-slot frames, codes latched into shadows only at frame wrap.
// Latency: led registered one cycle after phase/shadow; no backpressure. Optional LAMP_FADE_EN steps shadows by one code per frame.
module lamp_pwm_driver #(
    parameter int CLK_DIV = 25000
) (
    input  logic               clk,
    input  logic               rst_n,
    lamp_pwm_driver_if.slave   bus
);

    localparam int              PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_phase;
    logic [1:0]    r_shadow [6];
    logic [5:0]    r_led;
    logic          r_frame_start;

    logic [1:0]    w_code       [6];
    logic [1:0]    w_shadow_nxt [6];
    logic [5:0]    w_led_nxt;
    logic          w_tick;
    logic          w_wrap;

    assign w_code[5] = bus.LDC;
    assign w_code[4] = bus.LDB;
    assign w_code[3] = bus.LDA;
    assign w_code[2] = bus.RDA;
    assign w_code[1] = bus.RDB;
    assign w_code[0] = bus.RDC;

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_wrap = w_tick && (r_phase == 2'd3);

    // Number of lit slots out of four for a brightness code.
    function automatic logic [2:0] slots(input logic [1:0] code);
        case (code)
            2'b00:   slots = 3'd0;
            2'b01:   slots = 3'd2;
            2'b10:   slots = 3'd3;
            default: slots = 3'd4;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_led_nxt[i]    = bus.en && ({1'b0, r_phase} < slots(r_shadow[i]));
            w_shadow_nxt[i] = r_shadow[i];
`ifdef LAMP_FADE_EN
            if (!bus.en) begin
                w_shadow_nxt[i] = 2'b00;
            end else if (w_wrap) begin
                if (w_code[i] > r_shadow[i])
                    w_shadow_nxt[i] = r_shadow[i] + 2'd1;
                else if (w_code[i] < r_shadow[i])
                    w_shadow_nxt[i] = r_shadow[i] - 2'd1;
            end
`else
            if (!bus.en || w_wrap)
                w_shadow_nxt[i] = w_code[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_phase       <= 2'd0;
            r_led         <= 6'd0;
            r_frame_start <= 1'b0;
            for (int i = 0; i < 6; i++)
                r_shadow[i] <= 2'b00;
        end else begin
            r_led         <= w_led_nxt;
            r_frame_start <= bus.en && w_wrap;
            for (int i = 0; i < 6; i++)
                r_shadow[i] <= w_shadow_nxt[i];
            // Disabled: hold the frame at its start so re-enable begins at phase 0.
            if (!bus.en) begin
                r_presc <= '0;
                r_phase <= 2'd0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign bus.led         = r_led;
    assign bus.frame_start = r_frame_start;

endmodule

// File: doc/lamp_pwm_driver.md
Name: lamp_pwm_driver

Overview:
- Receiving end of the tail-lamp brightness-code interface: takes the six 2-bit brightness codes from the lamp FSM output logic and drives six physical LED pins with pulse-width modulation.
- Code meaning is fixed: 00 off, 01 50%, 10 75%, 11 100%.
- Sits between the lamp FSM and the board LED pins.
- Codes are sampled only at PWM frame boundaries, so mid-frame code changes never produce runt pulses.

Parameters:
- CLK_DIV, 25000, clk cycles per PWM slot, min 1; one frame = 4 slots = 4*CLK_DIV cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  driver enable; low forces all LEDs off
- LDC  in  2  brightness code, leftmost lamp
- LDB  in  2  brightness code
- LDA  in  2  brightness code
- RDA  in  2  brightness code
- RDB  in  2  brightness code
- RDC  in  2  brightness code, rightmost lamp
- led  out  6  LED drive; led[5]=LDC, led[4]=LDB, led[3]=LDA, led[2]=RDA, led[1]=RDB, led[0]=RDC; 1 = on
- frame_start  out  1  one-cycle pulse marking a shadow-code load

Behaviour:
- Reset (rst_n low, async): prescaler=0, phase=0, all six shadow codes=00, led=0, frame_start=0.
- Prescaler: counts 0..CLK_DIV-1. tick is asserted when prescaler==CLK_DIV-1, then the prescaler wraps to 0. With CLK_DIV=1, tick is asserted every cycle.
- Phase: 2-bit counter, increments on tick and wraps 3->0.
- Frame wrap: tick while phase==3.
  - Each shadow code loads from its input.
  - frame_start=1 in the following cycle; it is a registered pulse, exactly one cycle wide.
- Slots per code: 00->0, 01->2, 10->3, 11->4.
- LED output: registered. led[i](t+1) = en(t) && (phase(t) < slots(shadow_i(t))).
  - 11 gives a solid on.
  - 00 gives a solid off.
  - No glitches across the frame wrap.
- Input changes between wraps are ignored until the next wrap.
- en low:
  - Prescaler and phase are held at 0.
  - Shadows load from the inputs every cycle.
  - led=0 and frame_start=0 from the next cycle.
- en rising: the frame starts at phase 0 with the codes loaded in the last disabled cycle. No frame_start pulse occurs for this first frame.
- Reset mid-frame: immediate clear. After release, counting restarts from prescaler=0, phase=0, with shadows at 00 until the first wrap.
- All six lamps share the prescaler and phase. Lamps are independent in duty only.

Optional Feature:
- Macro: LAMP_FADE_EN.
- Defined:
  - At each frame wrap, each shadow code moves one step toward its input (+1 or -1) instead of jumping to it. If equal, no change.
  - While en is low, shadows are cleared to 00 instead of loading from the inputs.
  - Result: 00->11 takes 3 frames (01, 10, 11); 11->00 takes 3 frames.
- Undefined: shadows load directly, as described under Behaviour. No fade logic is synthesised.

Test Plan:
- CLK_DIV=2, en=1, all codes 11 held through 2 wraps -> after the first wrap, led=6'b111111 every cycle, and frame_start pulses once every 8 cycles.
- CLK_DIV=2, LDA=01, RDA=10, others 00 -> per 8-cycle frame after a wrap: led[3] high 4 consecutive cycles then low 4; led[2] high 6 then low 2; all other LED bits 0.
- CLK_DIV=2, LDC changes 00->11 at phase 1 mid-frame -> led[5] stays 0 until 1 cycle after the next wrap, then stays 1.
- en driven low mid-frame with all codes 11 -> led=0 the next cycle and frame_start stays 0. On en high, led=6'b111111 one cycle later, with no frame_start until the phase 3 tick.
- rst_n pulsed low mid-frame with codes 10 -> led=0 and frame_start=0 immediately (async). After release, led stays 0 until the first wrap, which occurs 8 cycles later.
- LAMP_FADE_EN defined, CLK_DIV=1, RDC steps 00->11 -> led[0] duty is 2/4, 3/4, 4/4 on successive frames. A later 11->00 step gives 3/4, 2/4, 0/4.
